// File: rtl/pixel_unpack.sv
// pixel_unpack: pops 48-bit words (two 24-bit pixels) from a show-ahead
// pixel FIFO and streams one pixel per cycle in raster order, tagging
// start-of-frame and end-of-line, with frame geometry from the attribute bus.

`ifndef ATTRMAX
`define ATTRMAX 31
`endif

module pixel_unpack (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [`ATTRMAX:0]   attr,
    input  logic [47:0]         fifodo,
    input  logic                fifoempty,
    output logic                fiforden,
    input  logic                pxready,
    output logic                pxvalid,
    output logic [23:0]         pxdata,
    output logic                pxsof,
    output logic                pxeol,
    output logic                done,
    output logic                underflow,
    output logic                busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Pixel halves of the FIFO head word: index 0 is the earlier pixel.
    logic [23:0] word_pix [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_split
            assign word_pix[gi] = fifodo[gi*24 +: 24];
        end
    endgenerate

    // Geometry as seen on the attribute bus right now.
    logic [15:0] attr_hact;
    logic [15:0] attr_vact;
    logic        attr_ok;

    assign attr_hact = attr[31:16];
    assign attr_vact = attr[15:0];
    assign attr_ok   = (attr_hact != 16'd0) && (attr_vact != 16'd0);

    state_t      state_reg,       state_next;
    logic [15:0] hact_m1_reg,     hact_m1_next;
    logic [15:0] vact_m1_reg,     vact_m1_next;
    logic [15:0] x_reg,           x_next;
    logic [15:0] y_reg,           y_next;
    logic [23:0] hold_reg,        hold_next;
    logic        hold_valid_reg,  hold_valid_next;
    logic        last_loaded_reg, last_loaded_next;
    logic        pxvalid_reg,     pxvalid_next;
    logic [23:0] pxdata_reg,      pxdata_next;
    logic        pxsof_reg,       pxsof_next;
    logic        pxeol_reg,       pxeol_next;
    logic        done_reg,        done_next;
    logic        underflow_reg,   underflow_next;

    // Per-cycle decode of the output slot and current raster position.
    logic        out_accept;
    logic        out_free;
    logic        at_eol;
    logic        at_last;
    logic        pop_req;
    logic        load;
    logic [23:0] load_pix;

    assign out_accept = pxvalid_reg && pxready;
    assign out_free   = !pxvalid_reg || pxready;
    assign at_eol     = (x_reg == hact_m1_reg);
    assign at_last    = at_eol && (y_reg == vact_m1_reg);

    // Next-state logic: frame control, pixel sourcing and raster advance.
    always_comb begin
        state_next       = state_reg;
        hact_m1_next     = hact_m1_reg;
        vact_m1_next     = vact_m1_reg;
        x_next           = x_reg;
        y_next           = y_reg;
        hold_next        = hold_reg;
        hold_valid_next  = hold_valid_reg;
        last_loaded_next = last_loaded_reg;
        pxvalid_next     = pxvalid_reg;
        pxdata_next      = pxdata_reg;
        pxsof_next       = pxsof_reg;
        pxeol_next       = pxeol_reg;
        done_next        = 1'b0;
        underflow_next   = underflow_reg;
        pop_req          = 1'b0;
        load             = 1'b0;
        load_pix         = 24'd0;

        case (state_reg)
            IDLE: begin
                pxvalid_next = 1'b0;
                if (start && attr_ok) begin
                    hact_m1_next     = attr_hact - 16'd1;
                    vact_m1_next     = attr_vact - 16'd1;
                    x_next           = 16'd0;
                    y_next           = 16'd0;
                    hold_valid_next  = 1'b0;
                    last_loaded_next = 1'b0;
                    underflow_next   = 1'b0;
                    state_next       = RUN;
                end
            end

            RUN: begin
                // The final pixel leaving the output register completes the frame.
                if (out_accept && last_loaded_reg) begin
                    done_next = 1'b1;
                end

                if (start) begin
                    // Restart: drop whatever is in flight and begin a fresh frame.
                    pxvalid_next     = 1'b0;
                    hold_valid_next  = 1'b0;
                    last_loaded_next = 1'b0;
                    if (attr_ok) begin
                        hact_m1_next   = attr_hact - 16'd1;
                        vact_m1_next   = attr_vact - 16'd1;
                        x_next         = 16'd0;
                        y_next         = 16'd0;
                        underflow_next = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (out_accept && last_loaded_reg) begin
                    pxvalid_next = 1'b0;
                    state_next   = IDLE;
                end else if (out_free) begin
                    if (last_loaded_reg) begin
                        pxvalid_next = 1'b0;
                    end else if (hold_valid_reg) begin
                        load            = 1'b1;
                        load_pix        = hold_reg;
                        hold_valid_next = 1'b0;
                    end else if (!fifoempty) begin
                        pop_req   = 1'b1;
                        load      = 1'b1;
                        load_pix  = word_pix[0];
                        hold_next = word_pix[1];
                        // A word whose first pixel ends the line carries no
                        // second pixel; lines always start on a fresh word.
                        hold_valid_next = !at_eol;
                    end else begin
                        pxvalid_next   = 1'b0;
                        underflow_next = 1'b1;
                    end
                end

                if (load) begin
                    pxvalid_next = 1'b1;
                    pxdata_next  = load_pix;
                    pxsof_next   = (x_reg == 16'd0) && (y_reg == 16'd0);
                    pxeol_next   = at_eol;
                    if (at_eol) begin
                        x_next = 16'd0;
                        if (at_last) begin
                            last_loaded_next = 1'b1;
                        end else begin
                            y_next = y_reg + 16'd1;
                        end
                    end else begin
                        x_next = x_reg + 16'd1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            hact_m1_reg     <= 16'd0;
            vact_m1_reg     <= 16'd0;
            x_reg           <= 16'd0;
            y_reg           <= 16'd0;
            hold_reg        <= 24'd0;
            hold_valid_reg  <= 1'b0;
            last_loaded_reg <= 1'b0;
            pxvalid_reg     <= 1'b0;
            pxdata_reg      <= 24'd0;
            pxsof_reg       <= 1'b0;
            pxeol_reg       <= 1'b0;
            done_reg        <= 1'b0;
            underflow_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            hact_m1_reg     <= hact_m1_next;
            vact_m1_reg     <= vact_m1_next;
            x_reg           <= x_next;
            y_reg           <= y_next;
            hold_reg        <= hold_next;
            hold_valid_reg  <= hold_valid_next;
            last_loaded_reg <= last_loaded_next;
            pxvalid_reg     <= pxvalid_next;
            pxdata_reg      <= pxdata_next;
            pxsof_reg       <= pxsof_next;
            pxeol_reg       <= pxeol_next;
            done_reg        <= done_next;
            underflow_reg   <= underflow_next;
        end
    end

    // The pop strobe is combinational; keep it quiet while reset is held.
    assign fiforden  = pop_req && !reset;
    assign pxvalid   = pxvalid_reg;
    assign pxdata    = pxdata_reg;
    assign pxsof     = pxsof_reg;
    assign pxeol     = pxeol_reg;
    assign done      = done_reg;
    assign underflow = underflow_reg;
    assign busy      = (state_reg == RUN);

endmodule

// File: tb/tb_pixel_unpack.sv
// tb_pixel_unpack: frame scenarios from a vector table, hand-written
// abort/reset/restart sequences and randomized frames, all checked against
// a raster reference built from the frame geometry and pixel list.

`ifndef ATTRMAX
`define ATTRMAX 31
`endif

module tb_pixel_unpack;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [`ATTRMAX:0]   attr;
    logic [47:0]         fifodo;
    logic                fifoempty;
    logic                fiforden;
    logic                pxready;
    logic                pxvalid;
    logic [23:0]         pxdata;
    logic                pxsof;
    logic                pxeol;
    logic                done;
    logic                underflow;
    logic                busy;

    pixel_unpack dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .attr      (attr),
        .fifodo    (fifodo),
        .fifoempty (fifoempty),
        .fiforden  (fiforden),
        .pxready   (pxready),
        .pxvalid   (pxvalid),
        .pxdata    (pxdata),
        .pxsof     (pxsof),
        .pxeol     (pxeol),
        .done      (done),
        .underflow (underflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hact;
        int vact;
        int rdy_mode;   // 0 always ready, 1 pattern 1,0,0,1, 2 random
        int feed_mode;  // 0 preloaded, 1 rest pushed at cycle gap, 2 random trickle
        int preload;    // words in FIFO before start (0 = all)
        int gap;
        int exp_pops;
        int exp_pix;
        int exp_uf;     // 2 = don't care
        int exp_done;   // cycle index of done after start (0 = don't care)
    } vec_t;

    int total = 0;
    int bad   = 0;

    logic [47:0] fifo_q [$];
    logic [47:0] src_q  [$];
    logic [25:0] exp_q  [$];   // {sof, eol, pixel}

    int feed_mode_g = 0;
    int gap_g       = 0;
    int fk          = 0;
    bit mon_on      = 0;
    int pops, dones, accepted, first_vld, done_cyc;
    bit stall_prev  = 0;
    logic [25:0] stall_word = '0;

    logic        s_vld, s_sof, s_eol, s_rd, s_done, s_uf, s_busy;
    logic [23:0] s_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic update_fifo();
        fifoempty = (fifo_q.size() == 0);
        fifodo    = fifoempty ? 48'hBAD000BAD000 : fifo_q[0];
    endtask

    task automatic feed();
        if (feed_mode_g == 1 && fk == gap_g) begin
            while (src_q.size() > 0) fifo_q.push_back(src_q.pop_front());
        end else if (feed_mode_g == 2 && src_q.size() > 0 && $urandom_range(0, 1) == 1) begin
            fifo_q.push_back(src_q.pop_front());
        end
    endtask

    function automatic logic rdy(input int mode, input int k);
        if (mode == 1) return (k % 4 == 0) || (k % 4 == 3);
        if (mode == 2) return 1'($urandom_range(0, 1));
        return 1'b1;
    endfunction

    // One clock: sample outputs mid-cycle, check the stream, then clock and pop.
    task automatic cycle();
        logic [25:0] got;
        logic [25:0] want;
        #1;
        s_vld  = pxvalid;
        s_data = pxdata;
        s_sof  = pxsof;
        s_eol  = pxeol;
        s_rd   = fiforden;
        s_done = done;
        s_uf   = underflow;
        s_busy = busy;
        got    = {s_sof, s_eol, s_data};
        if (mon_on) begin
            if (stall_prev) begin
                chk("stall_valid", 64'(s_vld), 64'd1);
                chk("stall_hold", 64'(got), 64'(stall_word));
            end
            if (s_rd) begin
                chk("pop_when_free", 64'(!s_vld || pxready), 64'd1);
                chk("pop_not_empty", 64'(fifoempty), 64'd0);
                pops++;
            end
            if (s_vld && first_vld < 0) first_vld = fk;
            if (s_vld && pxready) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 26'h3FFFFFF;
                accepted++;
                $display("px %0d data=%h sof=%0d eol=%0d", accepted, s_data, s_sof, s_eol);
                chk("pixel", 64'(got), 64'(want));
            end
            if (s_done) begin
                dones++;
                done_cyc = fk;
                chk("busy_at_done", 64'(s_busy), 64'd0);
            end
        end
        stall_prev = s_vld && !pxready;
        stall_word = got;
        @(posedge clk);
        #1;
        if (s_rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
        fk++;
        feed();
        update_fifo();
    endtask

    // Build the expected raster and FIFO words, run one frame, check totals.
    task automatic run_frame(input vec_t v, input bit rnd);
        logic [23:0] line [$];
        logic [23:0] p;
        logic [23:0] hi;
        int n = 0;
        int np;
        exp_q.delete();
        src_q.delete();
        fifo_q.delete();
        for (int y = 0; y < v.vact; y++) begin
            line.delete();
            for (int x = 0; x < v.hact; x++) begin
                p = rnd ? 24'($urandom) : 24'(n + 1);
                n++;
                line.push_back(p);
                exp_q.push_back({(x == 0 && y == 0), (x == v.hact - 1), p});
            end
            for (int w = 0; w < (v.hact + 1) / 2; w++) begin
                hi = (2 * w + 1 < v.hact) ? line[2 * w + 1] : (24'hBAD000 | 24'(w));
                src_q.push_back({hi, line[2 * w]});
            end
        end
        np = (v.preload == 0) ? src_q.size() : v.preload;
        for (int i = 0; i < np; i++) fifo_q.push_back(src_q.pop_front());
        update_fifo();
        feed_mode_g = v.feed_mode;
        gap_g       = v.gap;
        pops = 0; dones = 0; accepted = 0; first_vld = -1; done_cyc = -1;
        stall_prev = 0;
        mon_on = 1;
        fk = 0;
        attr = '0;
        attr[31:16] = 16'(v.hact);
        attr[15:0]  = 16'(v.vact);
        start = 1'b1;
        pxready = rdy(v.rdy_mode, 0);
        cycle();
        start = 1'b0;
        while (dones == 0 && fk < 500) begin
            pxready = rdy(v.rdy_mode, fk);
            cycle();
            if (fk == 2) begin
                chk("busy_running", 64'(s_busy), 64'd1);
                chk("underflow_cleared", 64'(s_uf), 64'd0);
            end
        end
        chk("frame_done", 64'(dones), 64'd1);
        if (v.exp_uf != 2) chk("underflow_flag", 64'(s_uf), 64'(v.exp_uf));
        if (v.exp_done != 0) chk("done_cycle", 64'(done_cyc), 64'(v.exp_done));
        feed_mode_g = 0;
        pxready = 1'b1;
        repeat (3) cycle();
        chk("single_done", 64'(dones), 64'd1);
        chk("pop_count", 64'(pops), 64'(v.exp_pops));
        chk("pixel_total", 64'(accepted), 64'(v.exp_pix));
        chk("nothing_left", 64'(exp_q.size()), 64'd0);
        chk("first_latency", 64'(first_vld), 64'd2);
        chk("idle_after", 64'({s_busy, s_vld}), 64'd0);
        mon_on = 0;
        fifo_q.delete();
        update_fifo();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pxvalid"}, 64'(s_vld), 64'd0);
        chk({tag, "_pxdata"}, 64'(s_data), 64'd0);
        chk({tag, "_flags"}, 64'({s_sof, s_eol, s_done, s_uf, s_busy, s_rd}), 64'd0);
    endtask

    vec_t tbl [7];
    vec_t rv;

    initial begin
        tbl[0] = '{4, 2, 0, 0, 0, 0, 4,  8, 0, 10};
        tbl[1] = '{3, 2, 0, 0, 0, 0, 4,  6, 0,  8};
        tbl[2] = '{4, 1, 1, 0, 0, 0, 2,  4, 0,  0};
        tbl[3] = '{4, 1, 0, 1, 1, 6, 2,  4, 1,  0};
        tbl[4] = '{5, 3, 2, 0, 0, 0, 9, 15, 0,  0};
        tbl[5] = '{1, 3, 0, 0, 0, 0, 3,  3, 0,  5};
        tbl[6] = '{6, 2, 1, 2, 1, 0, 6, 12, 2,  0};

        reset = 1'b1; start = 1'b0; attr = '0; pxready = 1'b1;
        fifo_q.push_back(48'h000002000001);
        update_fifo();
        repeat (3) cycle();
        reset = 1'b0;
        cycle();
        check_reset_outputs("reset");

        // Zero dimension: start is ignored, nothing popped.
        attr = '0; attr[31:16] = 16'd0; attr[15:0] = 16'd2;
        start = 1'b1; cycle(); start = 1'b0; cycle();
        chk("zero_hact_busy", 64'({s_busy, s_rd}), 64'd0);
        attr[31:16] = 16'd3; attr[15:0] = 16'd0;
        start = 1'b1; cycle(); start = 1'b0; cycle();
        chk("zero_vact_busy", 64'({s_busy, s_rd}), 64'd0);
        chk("zero_no_pop", 64'(fifo_q.size()), 64'd1);
        fifo_q.delete(); update_fifo();

        for (int i = 0; i < 7; i++) begin
            $display("scenario %0d hact=%0d vact=%0d", i, tbl[i].hact, tbl[i].vact);
            run_frame(tbl[i], 1'b0);
        end

        // Abort after 3 pixels of a large frame, restart as 2x1.
        for (int i = 0; i < 4; i++) fifo_q.push_back({24'(256 + 2 * i + 1), 24'(256 + 2 * i)});
        update_fifo();
        attr = '0; attr[31:16] = 16'd640; attr[15:0] = 16'd480;
        pxready = 1'b1;
        start = 1'b1; cycle(); start = 1'b0;
        cycle(); chk("abort_pop", 64'(s_rd), 64'd1);
        cycle(); cycle(); cycle();
        chk("abort_px3", 64'({s_vld, s_data}), 64'({1'b1, 24'd258}));
        start = 1'b1; attr[31:16] = 16'd2; attr[15:0] = 16'd1;
        cycle(); chk("abort_no_pop", 64'(s_rd), 64'd0);
        start = 1'b0;
        cycle();
        chk("abort_gap", 64'({s_vld, s_done}), 64'd0);
        chk("abort_repop", 64'(s_rd), 64'd1);
        cycle(); chk("abort_new0", 64'({s_vld, s_sof, s_eol, s_data}), 64'({3'b110, 24'd260}));
        cycle(); chk("abort_new1", 64'({s_vld, s_sof, s_eol, s_data}), 64'({3'b101, 24'd261}));
        cycle(); chk("abort_done", 64'({s_done, s_busy}), 64'b10);
        fifo_q.delete(); update_fifo(); cycle();

        // Last pixel accepted in the same cycle as a new start.
        fifo_q.push_back({24'hA1A1A1, 24'hA0A0A0});
        fifo_q.push_back({24'hB1B1B1, 24'hB0B0B0});
        update_fifo();
        attr = '0; attr[31:16] = 16'd2; attr[15:0] = 16'd1;
        start = 1'b1; cycle(); start = 1'b0;
        cycle(); cycle();
        chk("restart_a0", 64'(s_data), 64'h00A0A0A0);
        start = 1'b1; cycle(); start = 1'b0;
        chk("restart_a1", 64'({s_vld, s_eol, s_data}), 64'({2'b11, 24'hA1A1A1}));
        cycle(); chk("restart_busy", 64'({s_busy, s_rd}), 64'b11);
        cycle(); chk("restart_b0", 64'({s_vld, s_sof, s_data}), 64'({2'b11, 24'hB0B0B0}));
        cycle(); cycle(); chk("restart_done", 64'(s_done), 64'd1);
        fifo_q.delete(); update_fifo(); cycle();

        // Reset in the middle of a frame with a pixel on the output.
        for (int i = 0; i < 4; i++) fifo_q.push_back({24'(2 * i + 2), 24'(2 * i + 1)});
        update_fifo();
        attr = '0; attr[31:16] = 16'd4; attr[15:0] = 16'd2;
        start = 1'b1; cycle(); start = 1'b0;
        cycle(); cycle(); cycle();
        chk("midreset_pre", 64'(s_vld), 64'd1);
        reset = 1'b1; cycle();
        chk("midreset_no_pop", 64'(s_rd), 64'd0);
        reset = 1'b0; cycle();
        check_reset_outputs("midreset");
        fifo_q.delete(); update_fifo();
        run_frame(tbl[0], 1'b0);

        // Randomized frames with random backpressure and FIFO trickle.
        for (int r = 0; r < 8; r++) begin
            rv.hact = $urandom_range(1, 9);
            rv.vact = $urandom_range(1, 4);
            rv.rdy_mode = 2; rv.feed_mode = 2; rv.preload = 1; rv.gap = 0;
            rv.exp_pops = rv.vact * ((rv.hact + 1) / 2);
            rv.exp_pix  = rv.hact * rv.vact;
            rv.exp_uf = 2; rv.exp_done = 0;
            $display("random %0d hact=%0d vact=%0d", r, rv.hact, rv.vact);
            run_frame(rv, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_unpack.md
Name: pixel_unpack

Overview:
- Consumer end of the pixel FIFO written by the DMA/cursor path.
- Pops 48-bit FIFO words, each holding two 24-bit pixels.
- Emits one pixel per cycle in raster order over a valid/ready stream to the scan-out/timing stage.
- Frame geometry comes from the shared attribute bus; frames are framed with start-of-frame and end-of-line markers.

Parameters:
- None. Widths are fixed by the `ATTRMAX` define in dport.vh.

Ports:
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse: begin a new frame
- attr  in  `ATTRMAX+1  attribute bus; [15:0]=vact, [31:16]=hact
- fifodo  in  48  show-ahead FIFO head; [23:0]=first pixel, [47:24]=second pixel
- fifoempty  in  1  FIFO empty; fifodo valid when low
- fiforden  out  1  pop FIFO head this cycle
- pxready  in  1  downstream accepts pixel
- pxvalid  out  1  pxdata valid
- pxdata  out  24  pixel
- pxsof  out  1  qualifies pixel (0,0)
- pxeol  out  1  qualifies pixel x=hact-1
- done  out  1  one-cycle pulse when last pixel of frame is accepted
- underflow  out  1  sticky: FIFO ran dry mid-frame
- busy  out  1  frame in progress

Behaviour:
- Reset: pxvalid=0, pxdata=0, pxsof=0, pxeol=0, fiforden=0, done=0, underflow=0, busy=0. Counters zeroed; held half cleared; state IDLE.
- Synchronous reset has priority over every other event, including mid-frame.
- States: IDLE, RUN.
- IDLE:
  - On start with hact!=0 and vact!=0: latch hact/vact, x=0, y=0, clear underflow, go to RUN (busy=1 from next cycle).
  - start with a zero dimension is ignored.
- RUN, output register:
  - Output register is "free" if pxvalid=0 or (pxvalid&&pxready).
  - pxdata/pxsof/pxeol are held stable while pxvalid&&!pxready.
- RUN, pixel source:
  - A held second pixel (hold valid) is used first.
  - Otherwise fiforden = free && !fifoempty (combinational). The next edge loads fifodo[23:0] into the output register and fifodo[47:24] into hold.
  - Result: 1 pixel/cycle sustained when FIFO non-empty and pxready=1. Latency from FIFO non-empty to pxvalid is 1 cycle.
- x/y advance when a pixel is loaded into the output register.
  - pxsof=1 when the loaded pixel is x=0,y=0.
  - pxeol=1 when x=hact-1; x then wraps to 0 and y increments.
- Odd hact: the line's last word supplies one pixel. Its high half is discarded (hold not set), so every line starts on a fresh word.
- Last pixel (x=hact-1, y=vact-1) loaded: no further pops.
  - When that pixel is accepted: done=1 for one cycle, busy=0, state IDLE.
  - If the pixel is accepted while start is asserted in the same cycle, the new start is honoured.
- Underflow: in RUN, if a word is needed, the output register is free and fifoempty=1, set underflow (sticky until next accepted start).
  - pxvalid drops; stream stalls and resumes when data arrives. Pixels are never skipped.
- start during RUN: abort the frame at the next edge.
  - pxvalid=0; hold discarded; relatch attr; x=y=0; stay RUN; no done pulse.
  - fiforden=0 in the start cycle.
- Arithmetic: x, y are 16-bit unsigned; compares use latched hact-1/vact-1. attr changes mid-frame have no effect.

Test Plan:
- hact=4, vact=2, FIFO preloaded with words {24'h2,24'h1},{4,3},{6,5},{8,7}, pxready=1, start pulse -> pxdata 1..8 on consecutive cycles starting 1 cycle after start+1. pxsof only with 1; pxeol with 4 and 8. Exactly 4 fiforden pulses; done one cycle after pixel 8; busy low afterwards.
- hact=3, vact=2, words {2,1},{X,3},{5,4},{X,6} -> pixels 1,2,3,4,5,6. pxeol with 3 and 6. 4 pops; X halves never appear on pxdata.
- hact=4, vact=1, pxready toggled 1,0,0,1,... -> pxdata/pxsof/pxeol stable while pxready=0. No pixel lost or duplicated; fiforden only when output slot free.
- hact=4, vact=1, only first word present, second word written 5 cycles later -> pixels 1,2, then pxvalid=0 for the gap with underflow=1, then 3,4. done fires; underflow stays 1 until next start.
- Mid-frame start after 3 pixels of hact=640, vact=480 with new attr hact=2, vact=1 -> pxvalid=0 next cycle, no done. Next pixel comes from the next FIFO word and has pxsof=1; 2 pixels then done.
- reset asserted mid-frame with pxvalid=1 -> all outputs at reset values next edge. Subsequent start behaves as the first scenario.
